// File: rtl/issue_queue_pkg.sv
// Shared decode/issue types for the issue queue: queue entry, issued-op view, wakeup helper.
package issue_queue_pkg;

  localparam int unsigned IQ_NUM_PHYS_REGS = 36;
  localparam int unsigned IQ_PW            = $clog2(IQ_NUM_PHYS_REGS);
  localparam int unsigned IQ_SEQ_NUM_BITS  = 8;
  localparam int unsigned IQ_PAYLOAD_BITS  = 64;

  typedef logic [IQ_PW-1:0]           preg_t;
  typedef logic [IQ_SEQ_NUM_BITS-1:0] seq_num_t;
  typedef logic [IQ_PAYLOAD_BITS-1:0] payload_t;

  typedef struct packed {
    logic     val;
    payload_t payload;
    seq_num_t seq_num;
    preg_t    psrc0;
    preg_t    psrc1;
    logic     pend0;
    logic     pend1;
  } iq_entry_t;

  typedef struct packed {
    payload_t payload;
    seq_num_t seq_num;
    preg_t    psrc0;
    preg_t    psrc1;
  } iq_issue_t;

  // A pending source stays pending unless this cycle's completion writes its register.
  function automatic logic still_pending(logic pend, preg_t psrc, logic cmpl_val,
                                         preg_t cmpl_preg);
    return pend & ~(cmpl_val & (psrc == cmpl_preg));
  endfunction

endpackage

// File: rtl/issue_queue_select.sv
// Oldest-ready priority encoder: lowest set bit of ready wins.
module issue_queue_select #(
  parameter int unsigned P_DEPTH = 4,
  localparam int unsigned IW = $clog2(P_DEPTH)
) (
  input  logic [P_DEPTH-1:0] ready,
  output logic [IW-1:0]      idx,
  output logic               found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    // Scan downward so the lowest-index hit is the last one written.
    for (int i = P_DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// Collapsing issue queue with completion wakeup. Define ISSUE_QUEUE_OOO_EN to allow issue
// from any ready entry; by default only entry 0 may issue (strict in-order).
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int unsigned P_DEPTH         = 4,
  parameter int unsigned P_NUM_PHYS_REGS = IQ_NUM_PHYS_REGS,
  parameter int unsigned P_SEQ_NUM_BITS  = IQ_SEQ_NUM_BITS,
  parameter int unsigned P_PAYLOAD_BITS  = IQ_PAYLOAD_BITS,
  localparam int unsigned PW = $clog2(P_NUM_PHYS_REGS),
  localparam int unsigned CW = $clog2(P_DEPTH + 1),
  localparam int unsigned IW = $clog2(P_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq_val,
  output logic                      enq_rdy,
  input  logic [P_PAYLOAD_BITS-1:0] enq_payload,
  input  logic [P_SEQ_NUM_BITS-1:0] enq_seq_num,
  input  logic [PW-1:0]             enq_psrc0,
  input  logic [PW-1:0]             enq_psrc1,
  input  logic                      enq_pend0,
  input  logic                      enq_pend1,
  output logic                      iss_val,
  input  logic                      iss_rdy,
  output logic [P_PAYLOAD_BITS-1:0] iss_payload,
  output logic [P_SEQ_NUM_BITS-1:0] iss_seq_num,
  output logic [PW-1:0]             iss_psrc0,
  output logic [PW-1:0]             iss_psrc1,
  input  logic                      cmpl_val,
  input  logic [PW-1:0]             cmpl_preg,
  output logic [CW-1:0]             count
);

  iq_entry_t          ent_q   [P_DEPTH];
  iq_entry_t          ent_d   [P_DEPTH];
  iq_entry_t          shifted [P_DEPTH];
  iq_entry_t          new_ent;
  iq_issue_t          iss_op;
  logic [P_DEPTH-1:0] ready;
  logic [P_DEPTH-1:0] eligible;
  logic [IW-1:0]      sel_idx;
  logic               sel_found;
  logic               do_enq;
  logic               do_iss;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;
  logic [CW-1:0]      enq_idx;

  always_comb begin
    ready = '0;
    for (int i = 0; i < P_DEPTH; i++) begin
      ready[i] = ent_q[i].val & ~ent_q[i].pend0 & ~ent_q[i].pend1;
    end
  end

`ifdef ISSUE_QUEUE_OOO_EN
  assign eligible = ready;
`else
  always_comb begin
    eligible    = '0;
    eligible[0] = ready[0];
  end
`endif

  issue_queue_select #(
    .P_DEPTH(P_DEPTH)
  ) u_select (
    .ready(eligible),
    .idx  (sel_idx),
    .found(sel_found)
  );

  // Issue fields come straight from registered state; no enqueue bypass.
  always_comb begin
    iss_op.payload = ent_q[sel_idx].payload;
    iss_op.seq_num = ent_q[sel_idx].seq_num;
    iss_op.psrc0   = ent_q[sel_idx].psrc0;
    iss_op.psrc1   = ent_q[sel_idx].psrc1;
  end

  assign iss_val     = sel_found;
  assign iss_payload = iss_op.payload;
  assign iss_seq_num = iss_op.seq_num;
  assign iss_psrc0   = iss_op.psrc0;
  assign iss_psrc1   = iss_op.psrc1;
  assign count       = count_q;

  assign enq_rdy = (count_q < CW'(P_DEPTH));
  assign do_enq  = enq_val & enq_rdy;
  assign do_iss  = iss_val & iss_rdy;
  // With a concurrent issue everything above the hole drops by one, so the tail does too.
  assign enq_idx = do_iss ? (count_q - CW'(1)) : count_q;

  always_comb begin
    new_ent.val     = 1'b1;
    new_ent.payload = enq_payload;
    new_ent.seq_num = enq_seq_num;
    new_ent.psrc0   = enq_psrc0;
    new_ent.psrc1   = enq_psrc1;
    new_ent.pend0   = still_pending(enq_pend0, enq_psrc0, cmpl_val, cmpl_preg);
    new_ent.pend1   = still_pending(enq_pend1, enq_psrc1, cmpl_val, cmpl_preg);
  end

  always_comb begin
    for (int i = 0; i < P_DEPTH - 1; i++) begin
      shifted[i] = ent_q[i + 1];
    end
    shifted[P_DEPTH-1] = '0;
  end

  always_comb begin
    count_d = count_q + CW'(do_enq) - CW'(do_iss);
    for (int i = 0; i < P_DEPTH; i++) begin
      ent_d[i] = (do_iss && (i >= int'(sel_idx))) ? shifted[i] : ent_q[i];
      // Wakeup is applied after the shift so it lands on the entry's new slot.
      ent_d[i].pend0 = still_pending(ent_d[i].pend0, ent_d[i].psrc0, cmpl_val, cmpl_preg);
      ent_d[i].pend1 = still_pending(ent_d[i].pend1, ent_d[i].psrc1, cmpl_val, cmpl_preg);
      if (do_enq && (i == int'(enq_idx))) begin
        ent_d[i] = new_ent;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < P_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < P_DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed scoreboard bench for issue_queue: stimulus pushes expected issue order,
// a monitor branch pops and compares on every iss_val & iss_rdy.
module tb_issue_queue;

`ifdef ISSUE_QUEUE_OOO_EN
  localparam bit OOO = 1'b1;
`else
  localparam bit OOO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enq_val = 1'b0;
  logic        enq_rdy;
  logic [63:0] enq_payload = '0;
  logic [7:0]  enq_seq_num = '0;
  logic [5:0]  enq_psrc0 = '0;
  logic [5:0]  enq_psrc1 = '0;
  logic        enq_pend0 = 1'b0;
  logic        enq_pend1 = 1'b0;
  logic        iss_val;
  logic        iss_rdy = 1'b0;
  logic [63:0] iss_payload;
  logic [7:0]  iss_seq_num;
  logic [5:0]  iss_psrc0;
  logic [5:0]  iss_psrc1;
  logic        cmpl_val = 1'b0;
  logic [5:0]  cmpl_preg = '0;
  logic [2:0]  count;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  issue_queue dut (
    .clk        (clk),
    .rst        (rst),
    .enq_val    (enq_val),
    .enq_rdy    (enq_rdy),
    .enq_payload(enq_payload),
    .enq_seq_num(enq_seq_num),
    .enq_psrc0  (enq_psrc0),
    .enq_psrc1  (enq_psrc1),
    .enq_pend0  (enq_pend0),
    .enq_pend1  (enq_pend1),
    .iss_val    (iss_val),
    .iss_rdy    (iss_rdy),
    .iss_payload(iss_payload),
    .iss_seq_num(iss_seq_num),
    .iss_psrc0  (iss_psrc0),
    .iss_psrc1  (iss_psrc1),
    .cmpl_val   (cmpl_val),
    .cmpl_preg  (cmpl_preg),
    .count      (count)
  );

  function automatic logic [63:0] pl(input logic [7:0] s);
    return {8{s}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq_set(input logic [7:0] s, input logic [5:0] p0, input logic [5:0] p1,
                         input logic pd0, input logic pd1);
    enq_val     = 1'b1;
    enq_seq_num = s;
    enq_payload = pl(s);
    enq_psrc0   = p0;
    enq_psrc1   = p1;
    enq_pend0   = pd0;
    enq_pend1   = pd1;
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 20 && count != 3'd0; i++) step();
    check(name, 64'(count), 64'd0);
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && iss_val && iss_rdy) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_issue: got seq %0d, required no issue", iss_seq_num);
        end else begin
          e = exp_q.pop_front();
          check("issue_seq", 64'(iss_seq_num), 64'(e));
          check("issue_payload", iss_payload, pl(e));
        end
      end
    end
  endtask

  task automatic stimulus();
    step();
    step();
    rst = 1'b0;
    check("reset_count", 64'(count), 64'd0);
    check("reset_iss_val", 64'(iss_val), 64'd0);
    check("reset_enq_rdy", 64'(enq_rdy), 64'd1);

    // Fill to capacity with ready ops while execute stalls.
    for (int s = 0; s < 4; s++) begin
      enq_set(8'(s), 6'd1, 6'd2, 1'b0, 1'b0);
      step();
    end
    enq_val = 1'b0;
    check("fill_count", 64'(count), 64'd4);
    check("fill_enq_rdy", 64'(enq_rdy), 64'd0);
    check("fill_iss_val", 64'(iss_val), 64'd1);
    check("fill_iss_seq", 64'(iss_seq_num), 64'd0);
    for (int s = 0; s < 5; s++) exp_q.push_back(8'(s));

    // Full queue: issue frees a slot but the offered op is refused this cycle.
    iss_rdy = 1'b1;
    enq_set(8'd4, 6'd1, 6'd2, 1'b0, 1'b0);
    step();
    check("full_no_enq_count", 64'(count), 64'd3);
    check("full_enq_rdy_after", 64'(enq_rdy), 64'd1);
    step();
    enq_val = 1'b0;
    check("enq_and_iss_count", 64'(count), 64'd3);
    check("enq_and_iss_head", 64'(iss_seq_num), 64'd2);
    wait_empty("drain_fill");

    // Wakeup two cycles after enqueue; a non-matching completion must not wake.
    enq_set(8'd5, 6'd7, 6'd3, 1'b1, 1'b0);
    exp_q.push_back(8'd5);
    step();
    enq_val = 1'b0;
    check("wake_before", 64'(iss_val), 64'd0);
    cmpl_val  = 1'b1;
    cmpl_preg = 6'd8;
    step();
    check("wrong_preg", 64'(iss_val), 64'd0);
    cmpl_preg = 6'd7;
    step();
    cmpl_val = 1'b0;
    check("wake_iss_val", 64'(iss_val), 64'd1);
    check("wake_iss_seq", 64'(iss_seq_num), 64'd5);
    wait_empty("drain_wake");

    // Older op pending on p9, younger op ready.
    if (OOO) begin
      exp_q.push_back(8'd2);
      exp_q.push_back(8'd1);
    end else begin
      exp_q.push_back(8'd1);
      exp_q.push_back(8'd2);
    end
    enq_set(8'd1, 6'd9, 6'd3, 1'b1, 1'b0);
    step();
    enq_set(8'd2, 6'd1, 6'd3, 1'b0, 1'b0);
    step();
    enq_val = 1'b0;
    check("order_first_iss_val", 64'(iss_val), 64'(OOO));
    if (iss_val) check("order_first_seq", 64'(iss_seq_num), 64'd2);
    step();
    check("order_blocked_p9", 64'(iss_val), 64'd0);
    cmpl_val  = 1'b1;
    cmpl_preg = 6'd9;
    step();
    cmpl_val = 1'b0;
    check("order_p9_iss_val", 64'(iss_val), 64'd1);
    check("order_p9_seq", 64'(iss_seq_num), 64'd1);
    wait_empty("drain_order");

    // Completion coincident with enqueue clears the stored pend bit.
    enq_set(8'd6, 6'd4, 6'd12, 1'b0, 1'b1);
    cmpl_val  = 1'b1;
    cmpl_preg = 6'd12;
    exp_q.push_back(8'd6);
    step();
    enq_val  = 1'b0;
    cmpl_val = 1'b0;
    check("same_cycle_iss_val", 64'(iss_val), 64'd1);
    check("same_cycle_seq", 64'(iss_seq_num), 64'd6);
    wait_empty("drain_same_cycle");

    // Wakeup of an entry that shifts down on the same edge.
    iss_rdy = 1'b0;
    enq_set(8'd10, 6'd1, 6'd2, 1'b0, 1'b0);
    step();
    enq_set(8'd11, 6'd20, 6'd2, 1'b1, 1'b0);
    step();
    enq_val = 1'b0;
    exp_q.push_back(8'd10);
    exp_q.push_back(8'd11);
    check("shift_count", 64'(count), 64'd2);
    iss_rdy   = 1'b1;
    cmpl_val  = 1'b1;
    cmpl_preg = 6'd20;
    step();
    cmpl_val = 1'b0;
    check("shift_wake_iss_val", 64'(iss_val), 64'd1);
    check("shift_wake_seq", 64'(iss_seq_num), 64'd11);
    check("shift_wake_count", 64'(count), 64'd1);
    wait_empty("drain_shift");

    // Reset with three entries held discards them all.
    iss_rdy = 1'b0;
    for (int s = 20; s < 23; s++) begin
      enq_set(8'(s), 6'd1, 6'd2, 1'b0, 1'b0);
      step();
    end
    enq_val = 1'b0;
    check("pre_rst_count", 64'(count), 64'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_iss_val", 64'(iss_val), 64'd0);
    check("mid_rst_enq_rdy", 64'(enq_rdy), 64'd1);
    iss_rdy = 1'b1;
    step();
    step();
    step();
    check("post_rst_count", 64'(count), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter P_DEPTH, default 4, number of queue entries (>= 2).
REQ-002 Parameter P_NUM_PHYS_REGS, default 36, physical register count; PW = $clog2(P_NUM_PHYS_REGS).
REQ-003 Parameter P_SEQ_NUM_BITS, default 8, sequence-number width.
REQ-004 Parameter P_PAYLOAD_BITS, default 64, opaque decoded-op payload width (uop, waddr, preg, ppreg, pc, imm).
REQ-005 Ports, in order:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enq_val  in  1  decoder offers a renamed op.
- enq_rdy  out  1  queue accepts the op.
- enq_payload  in  P_PAYLOAD_BITS  op payload.
- enq_seq_num  in  P_SEQ_NUM_BITS  op sequence number.
- enq_psrc0, enq_psrc1  in  PW each  source physical registers.
- enq_pend0, enq_pend1  in  1 each  source not yet produced.
- iss_val  out  1  an op is offered to execute.
- iss_rdy  in  1  execute accepts the op.
- iss_payload, iss_seq_num, iss_psrc0, iss_psrc1  out  matching widths  issued op fields.
- cmpl_val  in  1  completion broadcast valid.
- cmpl_preg  in  PW  physical register just written.
- count  out  $clog2(P_DEPTH+1)  occupied entries.

Function
REQ-006 Storage SHALL be a collapsing queue: entry 0 oldest, valid entries contiguous from 0.
REQ-007 Enqueue SHALL occur on the edge where enq_val & enq_rdy; enq_rdy SHALL be (count < P_DEPTH), independent of iss_rdy.
REQ-008 An entry SHALL be ready when valid and both pend bits clear; iss_val SHALL be 1 iff some entry is ready, from registered state only.
REQ-009 Issue selection SHALL pick the lowest-index (oldest) ready entry; iss_* SHALL present that entry's fields.
REQ-010 On iss_val & iss_rdy the selected entry SHALL be removed and all higher entries shift down one slot at the edge.
REQ-011 Minimum enqueue-to-issue latency SHALL be one cycle; no combinational enq-to-iss bypass.
REQ-012 On cmpl_val, every valid entry SHALL clear pend0 (pend1) where psrc0 (psrc1) == cmpl_preg, at the edge.
REQ-013 Enqueue coincident with matching cmpl_val SHALL store the matching pend bit cleared.
REQ-014 Simultaneous enqueue and issue SHALL both take effect; new entry lands at index count-1; count unchanged.
REQ-015 Enqueue into the full queue SHALL not occur even when iss_rdy is 1 that cycle.
REQ-016 Wakeup of an entry being shifted SHALL apply to it at its new index.
REQ-017 count SHALL equal number of valid entries after every edge.

Reset
REQ-018 On rst all entries SHALL be invalid, count 0, iss_val 0, enq_rdy 1 the following cycle; payload contents are don't-care.
REQ-019 rst mid-operation SHALL discard all entries without issuing any.

Configuration
REQ-020 With ISSUE_QUEUE_OOO_EN defined, selection SHALL follow REQ-009 (oldest ready anywhere).
REQ-021 Without ISSUE_QUEUE_OOO_EN, only entry 0 SHALL be eligible: iss_val = entry 0 ready (strict in-order issue); all other requirements unchanged.

Structure
REQ-022 Entry struct typedef (val, payload, seq_num, psrc0/1, pend0/1) SHALL live in a shared package alongside the decode/issue types.
REQ-023 One sub-module, issue_queue_select, SHALL implement the oldest-ready priority encoder (index + found).

Verification
REQ-024 Fill: 4 enqueues, both pend 0, iss_rdy 0 -> count 4, enq_rdy 0, iss_val 1 with seq 0.
REQ-025 Wakeup: enqueue seq 5 psrc0=7 pend0=1; cmpl_val preg=7 two cycles later -> iss_val 1 the cycle after completion, iss_seq_num 5.
REQ-026 OOO (ISSUE_QUEUE_OOO_EN): seq 1 pending on p9, seq 2 ready, iss_rdy 1 -> seq 2 issues first; without macro iss_val stays 0 until p9 completes, then 1, 2 in order.
REQ-027 Enqueue with cmpl_val same cycle, cmpl_preg=enq_psrc1=12, pend1=1 -> entry ready, issues next cycle.
REQ-028 Full queue, iss_rdy 1, enq_val 1 -> one issue, no enqueue, count 3; next cycle enqueue accepted, count stays 3 with concurrent issue.
REQ-029 rst asserted with 3 entries -> next cycle count 0, iss_val 0, enq_rdy 1.
